// File: rtl/egress_meta_pkg.sv
// Shared field layout and word builder for the egress completion queue.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package egress_meta_pkg;

  localparam int PORT_W    = 2;
  localparam int META_W    = 28;
  localparam int VALID_BIT = 31;
  localparam int OVF_BIT   = 30;
  localparam int PORT_LSB  = 28;

  // Status word seen by software: valid, overflow, source port, payload.
  typedef struct packed {
    logic              valid;
    logic              ovf;
    logic [PORT_W-1:0] port;
    logic [11:0]       pkt_len;
    logic [15:0]       ts;
  } meta_word_t;

  // Assemble a valid status word from its fields.
  function automatic meta_word_t make_word(input logic              ovf,
                                           input logic [PORT_W-1:0] port,
                                           input logic [META_W-1:0] payload);
    logic [31:0] w;
    w                      = '0;
    w[VALID_BIT]           = 1'b1;
    w[OVF_BIT]             = ovf;
    w[PORT_LSB +: PORT_W]  = port;
    w[META_W-1:0]          = payload;
    return meta_word_t'(w);
  endfunction

endpackage

// File: rtl/egress_meta_queue_if.sv
// Bundles the egress record handshake and the software status-word signals.
// Latency: none (wires only).
// Backpressure: ready is produced by the slave (queue) side per port.
interface egress_meta_queue_if #(
  parameter int PORTS  = 4,
  parameter int META_W = 28,
  parameter int DEPTH  = 16
);
  logic [PORTS-1:0]        egress_meta_valid;
  logic [PORTS*META_W-1:0] egress_meta_data;
  logic [PORTS-1:0]        egress_meta_ready;
  logic                    interface_out_ack;
  logic [31:0]             interface_in;
  logic [$clog2(DEPTH):0]  queue_count;

  // Master: egress ports plus software ack source.
  modport master (
    output egress_meta_valid, egress_meta_data, interface_out_ack,
    input  egress_meta_ready, interface_in, queue_count
  );

  // Slave: the queue itself.
  modport slave (
    input  egress_meta_valid, egress_meta_data, interface_out_ack,
    output egress_meta_ready, interface_in, queue_count
  );
endinterface

// File: rtl/egress_meta_queue_rr_arbiter.sv
// Round-robin picker: one grant per cycle, search starts at the stored pointer.
// Latency: grant is combinational; pointer moves to winner+1 on the next edge.
// Backpressure: en=0 suppresses every grant and freezes the pointer.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_vld
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;

  // First requester at or after the pointer wins; N is a power of two so the index wraps for free.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr_q + IW'(i);
      if (en && !gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_vld) begin
      gnt[gnt_idx] = 1'b1;
    end
    ptr_d = gnt_vld ? gnt_idx + 1'b1 : ptr_q;
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/egress_meta_queue.sv
// Merges per-port completion records into a FIFO whose head is the software status word.
// Latency: accepted record visible on interface_in next cycle; ack rising edge pops, next head next cycle.
// Backpressure: per-port ready from round robin, all low when full; EGRESS_META_DROP_EN drops instead.
module egress_meta_queue #(
  parameter int PORTS  = 4,
  parameter int DEPTH  = 16,
  parameter int META_W = 28
) (
  input  logic                clk,
  input  logic                reset_n,
  egress_meta_queue_if.slave  bus
);
  import egress_meta_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SEL_W = $clog2(PORTS);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  meta_word_t       mem_q [DEPTH];
  meta_word_t       mem_d [DEPTH];
  logic [31:0]      head_q, head_d;
  logic             ack_q, ack_d;
  logic             ovf_q, ovf_d;

  logic             full, empty, ack_edge, pop, push, drop, arb_en;
  logic [PORTS-1:0] gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic [META_W-1:0] win_payload;
  meta_word_t       push_word;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

`ifdef EGRESS_META_DROP_EN
  // Arbitration never stalls; a winner arriving while full is thrown away.
  assign arb_en = 1'b1;
  assign push   = gnt_vld && !full;
  assign drop   = gnt_vld && full;
  assign bus.egress_meta_ready = {PORTS{reset_n}};
  logic unused_gnt;
  assign unused_gnt = &gnt;
`else
  // Full blocks every grant, even when software pops in the same cycle.
  assign arb_en = !full;
  assign push   = gnt_vld;
  assign drop   = 1'b0;
  assign bus.egress_meta_ready = gnt & {PORTS{reset_n}};
`endif

  rr_arbiter #(.N(PORTS)) u_arb (
    .clk     (clk),
    .rst_n   (reset_n),
    .en      (arb_en),
    .req     (bus.egress_meta_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign win_payload = bus.egress_meta_data[gnt_idx*META_W +: META_W];
  assign push_word   = make_word(ovf_q, gnt_idx, win_payload);
  assign ack_edge    = bus.interface_out_ack && !ack_q;
  assign pop         = ack_edge && !empty;

  // Queue next state; the head is read from the post-write array so a push into an empty queue shows up directly.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    ovf_d    = ovf_q;
    ack_d    = bus.interface_out_ack;
    head_d   = '0;
    if (push) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      ovf_d           = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (count_d != '0) begin
      head_d = mem_d[rd_ptr_d];
    end
  end

  // State registers; everything is discarded the moment reset asserts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
      head_q   <= '0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
      head_q   <= head_d;
      ack_q    <= ack_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.interface_in = head_q;
  assign bus.queue_count  = count_q;
endmodule

// File: tb/tb_egress_meta_queue.sv
module tb_egress_meta_queue;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  egress_meta_queue_if #(.PORTS(4), .META_W(28), .DEPTH(16)) bus ();

  egress_meta_queue #(.PORTS(4), .DEPTH(16), .META_W(28)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          m_ptr;
  logic        m_ackq;
  logic        m_ovf;
  logic [3:0]  exp_rdy, obs_rdy;
  logic [27:0] pdata [4];

  // One clock of stimulus; the reference queue and arbiter are advanced alongside.
  task automatic step();
    logic        full;
    int          win;
    logic        do_pop;
    logic [31:0] w;
    bus.egress_meta_data = {pdata[3], pdata[2], pdata[1], pdata[0]};
    full = (exp_q.size() == 16);
    win  = -1;
    for (int i = 0; i < 4; i++) begin
      int c;
      c = (m_ptr + i) % 4;
      if (win < 0 && bus.egress_meta_valid[c]) win = c;
    end
`ifdef EGRESS_META_DROP_EN
    exp_rdy = 4'hF;
`else
    exp_rdy = 4'h0;
    if (full) win = -1;
    if (win >= 0) exp_rdy[win] = 1'b1;
`endif
    #4;
    obs_rdy = bus.egress_meta_ready;
    do_pop  = bus.interface_out_ack && !m_ackq && (exp_q.size() > 0);
    m_ackq  = bus.interface_out_ack;
    if (do_pop) exp_q.delete(0);
    if (win >= 0) begin
      if (full) begin
        m_ovf = 1'b1;
      end else begin
        w = {1'b1, m_ovf, 2'(win), pdata[win]};
        exp_q.push_back(w);
        m_ovf = 1'b0;
      end
      m_ptr = (win + 1) % 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.egress_meta_valid = '0;
    bus.interface_out_ack = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    m_ptr = 0; m_ackq = 1'b0; m_ovf = 1'b0;
  endtask

  // Pops everything software should see, comparing each head against the scoreboard.
  task automatic drain(input string tag);
    int          guard;
    logic [31:0] e;
    guard = 0;
    bus.egress_meta_valid = '0;
    while (exp_q.size() > 0 && guard < 40) begin
      e = exp_q[0];
      n_cmp++;
      if (bus.interface_in !== e) begin
        n_err++;
        $display("FAIL %s_head: got %h want %h", tag, bus.interface_in, e);
      end
      bus.interface_out_ack = 1'b1; step();
      bus.interface_out_ack = 1'b0; step();
      n_cmp++;
      if (bus.queue_count !== 5'(exp_q.size())) begin
        n_err++;
        $display("FAIL %s_count: got %0d want %0d", tag, bus.queue_count, exp_q.size());
      end
      guard++;
    end
    n_cmp++;
    if (bus.interface_in !== 32'h0 || bus.queue_count !== 5'd0) begin
      n_err++;
      $display("FAIL %s_empty: got head %h count %0d want 0/0", tag, bus.interface_in, bus.queue_count);
    end
  endtask

  task automatic test_reset();
    for (int p = 0; p < 4; p++) pdata[p] = '0;
    bus.egress_meta_data  = '0;
    bus.egress_meta_valid = '0;
    bus.interface_out_ack = 1'b0;
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    bus.egress_meta_valid = 4'hF;
    #1;
    n_cmp++;
    if (bus.interface_in !== 32'h0) begin n_err++; $display("FAIL reset_head: got %h want 0", bus.interface_in); end
    n_cmp++;
    if (bus.queue_count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.queue_count); end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.egress_meta_ready !== 4'h0) begin n_err++; $display("FAIL reset_ready: got %b want 0000", bus.egress_meta_ready); end
    bus.egress_meta_valid = '0;
    reset_n = 1'b1;
    exp_q.delete();
    m_ptr = 0; m_ackq = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic test_single_push();
    pdata[2] = 28'h040_1234;
    bus.egress_meta_valid = 4'b0100;
    step();
    bus.egress_meta_valid = '0;
    n_cmp++;
    if (obs_rdy !== exp_rdy) begin n_err++; $display("FAIL single_ready: got %b want %b", obs_rdy, exp_rdy); end
    n_cmp++;
    if (bus.interface_in !== 32'hA040_1234) begin n_err++; $display("FAIL single_head: got %h want A0401234", bus.interface_in); end
    n_cmp++;
    if (bus.queue_count !== 5'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", bus.queue_count); end
  endtask

  task automatic test_pop();
    pdata[0] = 28'h000_0055;
    bus.egress_meta_valid = 4'b0001;
    step();
    bus.egress_meta_valid = '0;
    n_cmp++;
    if (bus.interface_in !== exp_q[0]) begin n_err++; $display("FAIL pop_head0: got %h want %h", bus.interface_in, exp_q[0]); end
    bus.interface_out_ack = 1'b1;
    step();
    n_cmp++;
    if (bus.interface_in !== 32'h8000_0055) begin n_err++; $display("FAIL pop_next: got %h want 80000055", bus.interface_in); end
    step(); step();
    n_cmp++;
    if (bus.queue_count !== 5'd1) begin n_err++; $display("FAIL pop_once: got %0d want 1", bus.queue_count); end
    bus.interface_out_ack = 1'b0; step();
    bus.interface_out_ack = 1'b1; step();
    n_cmp++;
    if (bus.interface_in !== 32'h0 || bus.queue_count !== 5'd0) begin
      n_err++; $display("FAIL pop_last: got head %h count %0d want 0/0", bus.interface_in, bus.queue_count);
    end
    step(); step();
    bus.interface_out_ack = 1'b0; step();
    bus.interface_out_ack = 1'b1; step();
    bus.interface_out_ack = 1'b0; step();
    pdata[1] = 28'h123_4567;
    bus.egress_meta_valid = 4'b0010;
    step();
    bus.egress_meta_valid = '0;
    n_cmp++;
    if (bus.queue_count !== 5'd1 || bus.interface_in !== 32'h9123_4567) begin
      n_err++; $display("FAIL empty_ack: got head %h count %0d want 91234567/1", bus.interface_in, bus.queue_count);
    end
  endtask

  task automatic test_back_to_back();
    pdata[3] = 28'hFED_0001;
    bus.egress_meta_valid = 4'b1000;
    bus.interface_out_ack = 1'b1;
    step();
    bus.interface_out_ack = 1'b0;
    n_cmp++;
    if (bus.queue_count !== 5'd1 || bus.interface_in !== 32'hBFED_0001) begin
      n_err++; $display("FAIL pushpop: got head %h count %0d want BFED0001/1", bus.interface_in, bus.queue_count);
    end
    for (int i = 0; i < 3; i++) begin
      pdata[3] = 28'h200_0000 + 28'(i);
      step();
      n_cmp++;
      if (obs_rdy !== exp_rdy) begin n_err++; $display("FAIL b2b_ready%0d: got %b want %b", i, obs_rdy, exp_rdy); end
    end
    bus.egress_meta_valid = '0;
    n_cmp++;
    if (bus.queue_count !== 5'd4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", bus.queue_count); end
    drain("b2b");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int p = 0; p < 4; p++) pdata[p] = 28'h0AB_0000 + 28'(p);
    bus.egress_meta_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (obs_rdy !== exp_rdy) begin n_err++; $display("FAIL rr_ready%0d: got %b want %b", k, obs_rdy, exp_rdy); end
    end
    bus.egress_meta_valid = '0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (bus.interface_in[29:28] !== 2'(k % 4) || bus.interface_in !== exp_q[0]) begin
        n_err++; $display("FAIL rr_order%0d: got %h want port %0d word %h", k, bus.interface_in, k % 4, exp_q[0]);
      end
      bus.interface_out_ack = 1'b1; step();
      bus.interface_out_ack = 1'b0; step();
    end
    n_cmp++;
    if (bus.queue_count !== 5'd0) begin n_err++; $display("FAIL rr_drained: got %0d want 0", bus.queue_count); end
  endtask

  task automatic fill16();
    bus.egress_meta_valid = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      pdata[0] = 28'h300_0000 + 28'(i);
      step();
      n_cmp++;
      if (obs_rdy !== exp_rdy) begin n_err++; $display("FAIL fill_ready%0d: got %b want %b", i, obs_rdy, exp_rdy); end
    end
    bus.egress_meta_valid = '0;
    n_cmp++;
    if (bus.queue_count !== 5'd16) begin n_err++; $display("FAIL fill_count: got %0d want 16", bus.queue_count); end
  endtask

`ifdef EGRESS_META_DROP_EN
  task automatic test_drop();
    do_reset();
    fill16();
    pdata[1] = 28'hDDD_DDDD;
    bus.egress_meta_valid = 4'b0010;
    step();
    bus.egress_meta_valid = '0;
    n_cmp++;
    if (obs_rdy !== 4'hF || bus.queue_count !== 5'd16) begin
      n_err++; $display("FAIL drop_full: got ready %b count %0d want 1111/16", obs_rdy, bus.queue_count);
    end
    bus.interface_out_ack = 1'b1; step();
    bus.interface_out_ack = 1'b0; step();
    pdata[3] = 28'h000_0001;
    bus.egress_meta_valid = 4'b1000;
    step();
    bus.egress_meta_valid = '0;
    n_cmp++;
    if (bus.queue_count !== 5'd16) begin n_err++; $display("FAIL drop_refill: got %0d want 16", bus.queue_count); end
    drain("drop");
  endtask
`else
  task automatic test_full();
    fill16();
    pdata[1] = 28'hFFF_0017;
    bus.egress_meta_valid = 4'b0010;
    step();
    n_cmp++;
    if (obs_rdy !== 4'h0 || bus.queue_count !== 5'd16) begin
      n_err++; $display("FAIL full_hold: got ready %b count %0d want 0000/16", obs_rdy, bus.queue_count);
    end
    bus.interface_out_ack = 1'b1;
    step();
    n_cmp++;
    if (obs_rdy !== 4'h0 || bus.queue_count !== 5'd15) begin
      n_err++; $display("FAIL full_popcycle: got ready %b count %0d want 0000/15", obs_rdy, bus.queue_count);
    end
    step();
    n_cmp++;
    if (obs_rdy !== 4'b0010 || bus.queue_count !== 5'd16) begin
      n_err++; $display("FAIL full_accept: got ready %b count %0d want 0010/16", obs_rdy, bus.queue_count);
    end
    bus.egress_meta_valid = '0;
    bus.interface_out_ack = 1'b0;
    step();
    drain("full");
  endtask
`endif

  task automatic test_reset_mid();
    bus.egress_meta_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      pdata[0] = 28'h000_0100 + 28'(i);
      step();
    end
    n_cmp++;
    if (bus.queue_count !== 5'd5) begin n_err++; $display("FAIL mid_count5: got %0d want 5", bus.queue_count); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.interface_in !== 32'h0 || bus.queue_count !== 5'd0 || bus.egress_meta_ready !== 4'h0) begin
      n_err++; $display("FAIL mid_reset: got head %h count %0d ready %b want 0/0/0000",
                        bus.interface_in, bus.queue_count, bus.egress_meta_ready);
    end
    bus.egress_meta_valid = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    m_ptr = 0; m_ackq = 1'b0; m_ovf = 1'b0;
    pdata[2] = 28'h040_1234;
    bus.egress_meta_valid = 4'b0100;
    step();
    bus.egress_meta_valid = '0;
    n_cmp++;
    if (bus.interface_in !== 32'hA040_1234 || bus.queue_count !== 5'd1) begin
      n_err++; $display("FAIL mid_resume: got head %h count %0d want A0401234/1", bus.interface_in, bus.queue_count);
    end
    drain("mid");
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_pop();
    test_back_to_back();
    test_round_robin();
`ifdef EGRESS_META_DROP_EN
    test_drop();
`else
    test_full();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
